axis_packetizer: RTL and testbench

Upstream framing stage for `axis_packet_combiner`. It takes an unframed AXI-Stream sample stream, such as ADC or DAC-FSM data that carries no TLAST, and cuts it into packets of a runtime-configurable length by asserting TLAST on every Nth beat. Output is fully registered and sustains one beat per cycle under continuous handshakes. A graceful enable lets software start and stop framing only on packet boundaries.

---
 rtl/axis_pkg.sv | 21 ++
 rtl/axis_skid_buffer.sv | 61 ++++++
 rtl/axis_packetizer.sv | 93 +++++++++
 tb/tb_axis_packetizer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream framing helpers: counter width, length clamp, and the packetizer state type.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } pkt_state_t;

    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Zero-length packets are meaningless, so 0 means a single-beat packet.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: registered ready upstream, registered valid/data downstream.
module axis_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             skid_valid;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data;
    logic             in_hs;
    logic             out_free;

    assign in_hs    = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;

    // Ready is registered, so it must be computed from where the skid slot will be next cycle.
    always_comb begin
        skid_valid_d = skid_valid;
        if (out_free) begin
            skid_valid_d = 1'b0;
        end else if (in_hs) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset as well so the output bus reads 0 during reset.
        if (!rst_n) begin
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            // NOTE: non-blocking throughout; every register here samples pre-edge values.
            s_ready    <= en && !skid_valid_d;
            skid_valid <= skid_valid_d;
            if (out_free) begin
                if (skid_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= skid_data;
                end else begin
                    m_valid <= in_hs;
                    if (in_hs) m_data <= s_data;
                end
            end else if (in_hs) begin
                skid_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Cuts an unframed AXI-Stream into packets of a runtime length by tagging TLAST on every Nth beat.
module axis_packetizer
    import axis_pkg::*;
#(
    parameter  int AXIS_TDATA_WIDTH  = 32,
    parameter  int MAX_PACKET_LENGTH = 1024,
    localparam int LW                = calc_lw(MAX_PACKET_LENGTH)
) (
    input  logic                        axis_aclk,
    input  logic                        axis_aresetn,
    input  logic                        cfg_enable,
    input  logic [LW-1:0]               cfg_packet_length,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [31:0]                 packet_count,
    output logic                        busy
);

    pkt_state_t    state;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_in;
    logic [LW-1:0] len_eff;
    logic          in_hs;
    logic          first_beat;
    logic          last_beat;
    logic          active_d;

    assign in_hs      = s_axis_tvalid && s_axis_tready;
    assign len_in     = LW'(clamp_len(32'(cfg_packet_length), MAX_PACKET_LENGTH));
    assign first_beat = (cnt == '0);
    // The first beat of a packet uses the live length, so a length of 1 tags TLAST immediately.
    assign len_eff    = first_beat ? len_in : len_q;
    assign last_beat  = (cnt + LW'(1) == len_eff);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        cnt_d = cnt;
        if (in_hs) cnt_d = last_beat ? '0 : cnt + LW'(1);
    end

    always_comb begin
        active_d = 1'b0;
        unique case (state)
            ST_IDLE:  active_d = cfg_enable;
            ST_RUN:   active_d = cfg_enable || (cnt_d != '0);
            ST_DRAIN: active_d = !(in_hs && last_beat);
            default:  active_d = 1'b0;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            len_q        <= '0;
            packet_count <= '0;
            busy         <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            busy <= active_d;
            if (in_hs && first_beat) len_q <= len_in;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) packet_count <= packet_count + 32'd1;
            unique case (state)
                ST_IDLE:  if (cfg_enable) state <= ST_RUN;
                ST_RUN:   if (!cfg_enable) state <= (cnt_d != '0) ? ST_DRAIN : ST_IDLE;
                ST_DRAIN: if (in_hs && last_beat) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .WIDTH(AXIS_TDATA_WIDTH + 1)
    ) u_skid (
        .clk    (axis_aclk),
        .rst_n  (axis_aresetn),
        .en     (active_d),
        .s_data ({last_beat, s_axis_tdata}),
        .s_valid(s_axis_tvalid),
        .s_ready(s_axis_tready),
        .m_data ({m_axis_tlast, m_axis_tdata}),
        .m_valid(m_axis_tvalid),
        .m_ready(m_axis_tready)
    );

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: directed framing scenarios followed by randomized traffic.
module tb_axis_packetizer;

    localparam int W    = 32;
    localparam int MAXL = 8;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk;
    logic          axis_aresetn;
    logic          cfg_enable;
    logic [LW-1:0] cfg_packet_length;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [31:0]   packet_count;
    logic          busy;

    axis_packetizer #(
        .AXIS_TDATA_WIDTH (W),
        .MAX_PACKET_LENGTH(MAXL)
    ) dut (
        .axis_aclk        (clk),
        .axis_aresetn     (axis_aresetn),
        .cfg_enable       (cfg_enable),
        .cfg_packet_length(cfg_packet_length),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .packet_count     (packet_count),
        .busy             (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           in_cyc[$];
    int           out_cyc[$];
    int           last_data_q[$];
    int           exp_lasts[$];
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    int           cyc       = 0;
    int           pos       = 0;
    int           cur_len   = 0;
    int           exp_pkts  = 0;
    int           ready_mode = 0;
    int           pidx      = 0;
    bit           pat[4];
    logic         stall     = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: actual %0h required %0h", name, act, req);
        else pass_cnt++;
    endtask

    function automatic int model_len(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAXL) return MAXL;
        return cfg;
    endfunction

    // Reference model and output monitor; all sampling happens mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!axis_aresetn) begin
            exp_q.delete();
            last_data_q.delete();
            pos      = 0;
            exp_pkts = 0;
            stall    = 1'b0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) begin
                beat_t b;
                if (pos == 0) cur_len = model_len(int'(cfg_packet_length));
                pos++;
                b.data = s_axis_tdata;
                b.last = (pos == cur_len);
                if (b.last) pos = 0;
                exp_q.push_back(b);
                in_cyc.push_back(cyc);
            end
            if (stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, stall_data);
                check("stall_last", m_axis_tlast, stall_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_last", m_axis_tlast, e.last);
                    if (e.last) exp_pkts++;
                end
                out_cyc.push_back(cyc);
                if (m_axis_tlast) last_data_q.push_back(int'(m_axis_tdata));
            end
            stall      = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_axis_tready = 1'b1;
            1: begin
                m_axis_tready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end
            default: m_axis_tready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic send(input logic [W-1:0] d, input int limit, output bit ok);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) s_axis_tvalid = 1'b0;
    endtask

    task automatic send_ok(input logic [W-1:0] d);
        bit ok;
        send(d, 30, ok);
        check("send_accept", ok, 1);
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_axis_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, done, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_lasts(input string name);
        check({name, "_tlast_count"}, last_data_q.size(), exp_lasts.size());
        for (int i = 0; i < exp_lasts.size() && i < last_data_q.size(); i++)
            check({name, "_tlast_beat"}, last_data_q[i], exp_lasts[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        axis_aresetn  = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_m_last", m_axis_tlast, 0);
        check("rst_m_data", m_axis_tdata, 0);
        check("rst_pkt_count", packet_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        axis_aresetn = 1'b1;
    endtask

    initial begin
        bit   ok;
        logic hs;
        axis_aresetn      = 1'b0;
        cfg_enable        = 1'b0;
        cfg_packet_length = LW'(3);
        s_axis_tvalid     = 1'b0;
        s_axis_tdata      = '0;
        m_axis_tready     = 1'b1;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // Back-to-back length-3 packets with an always-ready sink.
        do_reset();
        cfg_enable = 1'b1;
        in_cyc.delete();
        out_cyc.delete();
        for (int d = 1; d <= 9; d++) send_ok(W'(d));
        wait_drain("t1");
        check("t1_in_count", in_cyc.size(), 9);
        check("t1_out_count", out_cyc.size(), 9);
        if (in_cyc.size() == 9 && out_cyc.size() == 9) begin
            check("t1_in_gapless", in_cyc[8] - in_cyc[0], 8);
            check("t1_out_gapless", out_cyc[8] - out_cyc[0], 8);
            check("t1_latency", out_cyc[0] - in_cyc[0], 1);
        end
        exp_lasts = {3, 6, 9};
        check_lasts("t1");
        check("t1_pkt_count", packet_count, 3);

        // Length 4 under a 1,0,0,1 ready pattern.
        do_reset();
        cfg_packet_length = LW'(4);
        pidx       = 0;
        ready_mode = 1;
        for (int d = 1; d <= 12; d++) send_ok(W'(d));
        ready_mode = 0;
        wait_drain("t2");
        exp_lasts = {4, 8, 12};
        check_lasts("t2");
        check("t2_pkt_count", packet_count, 3);

        // Mid-packet length change only takes effect on the next packet.
        do_reset();
        cfg_packet_length = LW'(3);
        send_ok(1);
        send_ok(2);
        cfg_packet_length = LW'(5);
        for (int d = 3; d <= 10; d++) send_ok(W'(d));
        wait_drain("t3");
        exp_lasts = {3, 8};
        check_lasts("t3");
        check("t3_pkt_count", packet_count, 2);

        // Graceful disable after beat 4 finishes the open packet.
        do_reset();
        cfg_packet_length = LW'(3);
        for (int d = 1; d <= 4; d++) send_ok(W'(d));
        cfg_enable = 1'b0;
        send_ok(5);
        check("t4_busy_in_drain", busy, 1);
        send_ok(6);
        send(7, 6, ok);
        check("t4_beat7_refused", ok, 0);
        wait_drain("t4");
        check("t4_ready_off", s_axis_tready, 0);
        check("t4_busy_off", busy, 0);
        exp_lasts = {3, 6};
        check_lasts("t4");
        check("t4_pkt_count", packet_count, 2);
        cfg_enable = 1'b1;

        // Lengths 0 and 1 both give single-beat packets.
        do_reset();
        cfg_packet_length = LW'(0);
        for (int d = 0; d <= 2; d++) send_ok(W'(d));
        cfg_packet_length = LW'(1);
        for (int d = 3; d <= 5; d++) send_ok(W'(d));
        wait_drain("t5");
        exp_lasts = {0, 1, 2, 3, 4, 5};
        check_lasts("t5");
        check("t5_pkt_count", packet_count, 6);

        // Reset in the middle of a packet restarts framing at beat 0.
        do_reset();
        cfg_packet_length = LW'(3);
        send_ok(1);
        send_ok(2);
        do_reset();
        for (int d = 10; d <= 12; d++) send_ok(W'(d));
        wait_drain("t6");
        exp_lasts = {12};
        check_lasts("t6");
        check("t6_pkt_count", packet_count, 1);

        // Randomized traffic, lengths (including clamped ones), backpressure and enable toggling.
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (hs || !s_axis_tvalid) begin
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                s_axis_tdata  = $urandom;
            end
            if ($urandom_range(0, 19) == 0) cfg_packet_length = LW'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) cfg_enable = !cfg_enable;
        end
        ready_mode = 0;
        cfg_enable = 1'b1;
        wait_drain("rand");
        check("rand_pkt_count", packet_count, exp_pkts);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
